// File: rtl/c7becl_excp_pkg.sv
// Shared definitions for the exception collection stage: exception codes,
// flush state encoding, the d->e pipeline record and the priority encoder.
package c7becl_excp_pkg;

    // Exception codes as seen by the CSR block (ESTAT.Ecode)
    localparam logic [5:0] EXC_INT  = 6'h00;
    localparam logic [5:0] EXC_ADEF = 6'h08;
    localparam logic [5:0] EXC_ALE  = 6'h09;
    localparam logic [5:0] EXC_SYS  = 6'h0B;
    localparam logic [5:0] EXC_BRK  = 6'h0C;
    localparam logic [5:0] EXC_INE  = 6'h0D;

    // RUN: events allowed; FLUSH: wrong-path window after an event
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ecl_state_e;

    // Contents of the d->e pipeline register
    typedef struct packed {
        logic valid;
        logic adef;
        logic ine;
        logic sys;
        logic brk;
        logic ertn;
    } de_reg_t;

    // Highest-priority source wins; interrupts outrank every synchronous cause
    function automatic logic [5:0] exc_prio(
        input logic int_pend,
        input logic adef,
        input logic ine,
        input logic sys,
        input logic brk,
        input logic ale
    );
        logic [5:0] code;
        if (int_pend) begin
            code = EXC_INT;
        end else if (adef) begin
            code = EXC_ADEF;
        end else if (ine) begin
            code = EXC_INE;
        end else if (sys) begin
            code = EXC_SYS;
        end else if (brk) begin
            code = EXC_BRK;
        end else if (ale) begin
            code = EXC_ALE;
        end else begin
            code = EXC_INT;
        end
        return code;
    endfunction

endpackage

// File: rtl/c7becl_excp_sync2.sv
// Two-flop synchroniser for asynchronous interrupt lines.
module c7becl_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/c7becl_excp.sv
// Exception/interrupt collection stage: carries decode-time exception flags
// into _e, merges them with misalignment and pending interrupts, produces
// one prioritised event per retiring instruction and then holds off further
// events for a flush window while the wrong path drains.
module c7becl_excp
    import c7becl_excp_pkg::*;
#(
    parameter int FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ifu_exu_valid_d,
    input  logic        ifu_exu_adef_d,
    input  logic        ifu_exu_illinst_d,
    input  logic        ifu_exu_syscall_d,
    input  logic        ifu_exu_brk_d,
    input  logic        ifu_exu_ertn_d,
    input  logic        ecl_stall,
    input  logic [31:0] ifu_exu_pc_e,
    input  logic        lsu_ale_e,
    input  logic [31:0] lsu_addr_e,
    input  logic        csr_ecl_crmd_ie,
    input  logic        csr_ecl_timer_intr,
    input  logic        ext_intr,
    output logic        exu_ifu_except,
    output logic        exu_ifu_ertn,
    output logic        ecl_csr_ertn_e,
    output logic [5:0]  ecl_csr_exccode_e,
    output logic [31:0] ecl_csr_badv_e,
    output logic        ecl_ext_intr_sync
);

    localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYC - 1);

    de_reg_t    de_q;
    de_reg_t    de_d;
    ecl_state_e state_q;
    ecl_state_e state_d;
    logic [2:0] fcnt_q;
    logic [2:0] fcnt_d;

    logic        ext_s;
    logic        int_pend_s;
    logic        go_s;
    logic        exc_any_s;
    logic        except_s;
    logic        ertn_s;
    logic [5:0]  code_s;

    c7becl_sync2 u_ext_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (ext_intr),
        .q_o    (ext_s)
    );

    // Event qualification: only an unstalled valid _e instruction in RUN retires
    always_comb begin
        int_pend_s = csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_s);
        go_s       = de_q.valid & ~ecl_stall & (state_q == ST_RUN);
        exc_any_s  = de_q.adef | de_q.ine | de_q.sys | de_q.brk | lsu_ale_e;
        except_s   = go_s & (int_pend_s | exc_any_s);
        ertn_s     = go_s & de_q.ertn & ~int_pend_s;
        code_s     = exc_prio(int_pend_s, de_q.adef, de_q.ine, de_q.sys,
                              de_q.brk, lsu_ale_e);
    end

    // d->e next value: squash the incoming instruction during flush or on an event
    always_comb begin
        de_d = de_q;
        if (!ecl_stall) begin
            de_d.valid = ifu_exu_valid_d & (state_q == ST_RUN) & ~(except_s | ertn_s);
            de_d.adef  = ifu_exu_adef_d;
            de_d.ine   = ifu_exu_illinst_d;
            de_d.sys   = ifu_exu_syscall_d;
            de_d.brk   = ifu_exu_brk_d;
            de_d.ertn  = ifu_exu_ertn_d;
        end else begin
            de_d = de_q;
        end
    end

    // d->e pipeline register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    // Flush window sequencing; the counter runs even while stalled
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (except_s | ertn_s) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end else begin
                    state_d = ST_RUN;
                    fcnt_d  = 3'd0;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == 3'd0) begin
                    state_d = ST_RUN;
                    fcnt_d  = 3'd0;
                end else begin
                    state_d = ST_FLUSH;
                    fcnt_d  = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    // State and flush counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Event outputs; code and badv are zero whenever no exception is signalled
    always_comb begin
        exu_ifu_except    = 1'b0;
        exu_ifu_ertn      = 1'b0;
        ecl_csr_ertn_e    = 1'b0;
        ecl_csr_exccode_e = 6'h00;
        ecl_csr_badv_e    = 32'h0000_0000;
        if (state_q == ST_RUN) begin
            exu_ifu_except = except_s;
            exu_ifu_ertn   = ertn_s;
            ecl_csr_ertn_e = ertn_s;
            if (except_s) begin
                ecl_csr_exccode_e = code_s;
                case (code_s)
                    EXC_ADEF: ecl_csr_badv_e = ifu_exu_pc_e;
                    EXC_ALE:  ecl_csr_badv_e = lsu_addr_e;
                    default:  ecl_csr_badv_e = 32'h0000_0000;
                endcase
            end else begin
                ecl_csr_exccode_e = 6'h00;
                ecl_csr_badv_e    = 32'h0000_0000;
            end
        end else begin
            exu_ifu_except    = 1'b0;
            exu_ifu_ertn      = 1'b0;
            ecl_csr_ertn_e    = 1'b0;
            ecl_csr_exccode_e = 6'h00;
            ecl_csr_badv_e    = 32'h0000_0000;
        end
    end

    assign ecl_ext_intr_sync = ext_s;

endmodule

// File: tb/tb_c7becl_excp.sv
// Scoreboard bench for c7becl_excp: a cycle-level reference model predicts
// events and the synchronised interrupt line; a negedge monitor compares.
module tb_c7becl_excp;

    localparam int F = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_d, adef_d, ill_d, sys_d, brk_d, ertn_d, stall;
    logic [31:0] pc_e, addr_e;
    logic        ale_e, ie, timer, ext_intr;
    logic        except_o, ertn_o, csr_ertn_o, sync_o;
    logic [5:0]  code_o;
    logic [31:0] badv_o;

    always #5 clk = ~clk;

    c7becl_excp #(.FLUSH_CYC(F)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .ifu_exu_valid_d    (valid_d),
        .ifu_exu_adef_d     (adef_d),
        .ifu_exu_illinst_d  (ill_d),
        .ifu_exu_syscall_d  (sys_d),
        .ifu_exu_brk_d      (brk_d),
        .ifu_exu_ertn_d     (ertn_d),
        .ecl_stall          (stall),
        .ifu_exu_pc_e       (pc_e),
        .lsu_ale_e          (ale_e),
        .lsu_addr_e         (addr_e),
        .csr_ecl_crmd_ie    (ie),
        .csr_ecl_timer_intr (timer),
        .ext_intr           (ext_intr),
        .exu_ifu_except     (except_o),
        .exu_ifu_ertn       (ertn_o),
        .ecl_csr_ertn_e     (csr_ertn_o),
        .ecl_csr_exccode_e  (code_o),
        .ecl_csr_badv_e     (badv_o),
        .ecl_ext_intr_sync  (sync_o)
    );

    typedef struct {
        int        cyc;
        bit        exc;
        bit        ert;
        bit [5:0]  code;
        bit [31:0] badv;
    } ev_t;

    ev_t ev_q[$];
    bit  sync_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  mon_on = 1'b0;

    // Reference model state: instruction sitting in _e, quiet window, ext history
    bit m_valid, m_adef, m_ine, m_sys, m_brk, m_ertn;
    int m_quiet;
    bit ext_h1, ext_h2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic idle();
        valid_d = 1'b0; adef_d = 1'b0; ill_d = 1'b0; sys_d = 1'b0;
        brk_d = 1'b0; ertn_d = 1'b0; stall = 1'b0; ale_e = 1'b0;
        ie = 1'b0; timer = 1'b0; ext_intr = 1'b0;
        pc_e = 32'h1C00_0000; addr_e = 32'h0000_0000;
    endtask

    task automatic model_reset();
        m_valid = 0; m_adef = 0; m_ine = 0; m_sys = 0; m_brk = 0; m_ertn = 0;
        m_quiet = 0; ext_h1 = 0; ext_h2 = 0;
    endtask

    // One cycle with the current inputs: predict, record, advance to next cycle
    task automatic step();
        bit        ip, go, exc, ert;
        bit        src[6];
        bit [5:0]  codes[6];
        ev_t       e;
        ip  = ie & (timer | ext_h2);
        go  = m_valid && !stall && (m_quiet == 0);
        src = '{ip, m_adef, m_ine, m_sys, m_brk, ale_e};
        codes = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        exc = go && (src[0] | src[1] | src[2] | src[3] | src[4] | src[5]);
        ert = go && m_ertn && !ip;
        sync_q.push_back(ext_h2);
        if (exc || ert) begin
            e.cyc = cyc; e.exc = exc; e.ert = ert; e.code = 6'h00; e.badv = 32'h0;
            if (exc) begin
                for (int i = 5; i >= 0; i--) if (src[i]) e.code = codes[i];
                if (e.code == 6'h08) e.badv = pc_e;
                if (e.code == 6'h09) e.badv = addr_e;
            end
            ev_q.push_back(e);
        end
        if (!stall) begin
            m_valid = valid_d && (m_quiet == 0) && !(exc || ert);
            m_adef = adef_d; m_ine = ill_d; m_sys = sys_d; m_brk = brk_d; m_ertn = ertn_d;
        end
        if (exc || ert) m_quiet = F;
        else if (m_quiet > 0) m_quiet--;
        ext_h2 = ext_h1;
        ext_h1 = ext_intr;
        mon_on = 1'b1;
        @(posedge clk); #1; cyc++;
    endtask

    // Hold reset for n cycles starting now; outputs must drop immediately
    task automatic reset_cycles(input int n);
        resetn = 1'b0;
        idle();
        #1;
        chk("rst_except", except_o, 1'b0);
        chk("rst_ertn", ertn_o, 1'b0);
        chk("rst_code", code_o, 6'h00);
        chk("rst_badv", badv_o, 32'h0);
        chk("rst_sync", sync_o, 1'b0);
        for (int i = 0; i < n; i++) begin
            model_reset();
            sync_q.push_back(1'b0);
            mon_on = 1'b1;
            @(posedge clk); #1; cyc++;
        end
        resetn = 1'b1;
    endtask

    // Monitor: pop expectations when the DUT shows an event
    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            if (sync_q.size() > 0) chk("ext_sync", sync_o, sync_q.pop_front());
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                tests++; fails++;
                $display("FAIL missed_event cyc=%0d expected_at=%0d code=%h", cyc, ev_q[0].cyc, ev_q[0].code);
                void'(ev_q.pop_front());
            end
            if (except_o || ertn_o || csr_ertn_o) begin
                if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
                    tests++; fails++;
                    $display("FAIL unexpected_event cyc=%0d except=%b ertn=%b code=%h exp=none",
                             cyc, except_o, ertn_o, code_o);
                end else begin
                    e = ev_q.pop_front();
                    chk("ev_except", except_o, e.exc);
                    chk("ev_ertn", ertn_o, e.ert);
                    chk("ev_csr_ertn", csr_ertn_o, e.ert);
                    if (e.exc) begin
                        chk("ev_code", code_o, e.code);
                        chk("ev_badv", badv_o, e.badv);
                    end
                end
            end
        end
    end

    initial begin
        idle();
        resetn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_cycles(2);

        // Illegal instruction, then flush suppresses a following syscall
        idle(); valid_d = 1'b1; ill_d = 1'b1; step();
        idle(); pc_e = 32'h1C00_0010; #1;
        chk("ill_except", except_o, 1'b1);
        chk("ill_code", code_o, 6'h0D);
        chk("ill_badv", badv_o, 32'h0);
        step();
        for (int i = 0; i < F; i++) begin
            idle(); valid_d = 1'b1; sys_d = 1'b1; #1;
            chk("flush_quiet", except_o, 1'b0);
            step();
        end
        idle(); repeat (3) step();

        // ALE alone, then ADEF outranking ALE
        idle(); valid_d = 1'b1; step();
        idle(); ale_e = 1'b1; addr_e = 32'h0000_1002; #1;
        chk("ale_code", code_o, 6'h09);
        chk("ale_badv", badv_o, 32'h0000_1002);
        step();
        idle(); repeat (F + 1) step();
        idle(); valid_d = 1'b1; adef_d = 1'b1; step();
        idle(); ale_e = 1'b1; addr_e = 32'h0000_1002; pc_e = 32'h1C00_0021; #1;
        chk("adef_code", code_o, 6'h08);
        chk("adef_badv", badv_o, 32'h1C00_0021);
        step();
        idle(); repeat (F + 1) step();

        // Interrupt beats ertn; without ie the ertn executes
        idle(); valid_d = 1'b1; ertn_d = 1'b1; step();
        idle(); ie = 1'b1; timer = 1'b1; #1;
        chk("int_ertn_except", except_o, 1'b1);
        chk("int_ertn_ertn", ertn_o, 1'b0);
        step();
        idle(); repeat (F + 1) step();
        idle(); valid_d = 1'b1; ertn_d = 1'b1; step();
        idle(); timer = 1'b1; #1;
        chk("ertn_only", ertn_o, 1'b1);
        chk("ertn_no_except", except_o, 1'b0);
        step();
        idle(); repeat (F + 1) step();

        // External interrupt through the synchroniser
        idle(); valid_d = 1'b1; ie = 1'b1; repeat (3) step();
        ext_intr = 1'b1; step();
        step();
        #1;
        chk("ext_sync_n2", sync_o, 1'b1);
        chk("ext_int_code", code_o, 6'h00);
        step();
        idle(); repeat (F + 3) step();

        // Stall holds a syscall, then release; flush lasts F cycles
        idle(); valid_d = 1'b1; sys_d = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            idle(); stall = 1'b1; #1;
            chk("stall_quiet", except_o, 1'b0);
            step();
        end
        idle(); #1;
        chk("stall_release_code", code_o, 6'h0B);
        step();
        idle(); valid_d = 1'b1; brk_d = 1'b1;
        repeat (F + 3) step();
        idle(); repeat (F + 1) step();

        // Reset one cycle into flush, then a break fires with no flush left
        idle(); valid_d = 1'b1; ill_d = 1'b1; step();
        idle(); step();
        reset_cycles(1);
        idle(); valid_d = 1'b1; brk_d = 1'b1; step();
        idle(); #1;
        chk("post_rst_brk", code_o, 6'h0C);
        step();
        idle(); repeat (F + 1) step();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                reset_cycles(1 + (n % 2));
            end else begin
                valid_d = ($urandom_range(0, 3) != 0);
                adef_d  = ($urandom_range(0, 15) == 0);
                ill_d   = ($urandom_range(0, 15) == 0);
                sys_d   = ($urandom_range(0, 15) == 0);
                brk_d   = ($urandom_range(0, 15) == 0);
                ertn_d  = ($urandom_range(0, 12) == 0);
                stall   = ($urandom_range(0, 4) == 0);
                ale_e   = ($urandom_range(0, 9) == 0);
                ie      = ($urandom_range(0, 3) == 0);
                timer   = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0) ext_intr = ~ext_intr;
                pc_e    = $urandom;
                addr_e  = $urandom;
                step();
            end
        end

        idle(); repeat (F + 2) step();
        @(negedge clk); #1;
        chk("queue_drained", ev_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
